// File: rtl/half_adder_seq_ctrl.sv
// WIDTH-bit ripple adder with carry-in, done bit-serially on one shared external half adder.
// Optional build macro SIGNED_OVF_EN adds the signed-overflow output ovf.
module half_adder_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             ha_x,
    output logic             ha_y,
    input  logic             ha_s,
    input  logic             ha_c
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             p;
    logic             g1;
    logic [IW-1:0]    idx;
    logic             carry_out;

    // PH_A forms propagate/generate of the operand bits; PH_B folds in the running carry.
    always_comb begin
        ha_x = 1'b0;
        ha_y = 1'b0;
        case (state)
            PH_A: begin
                ha_x = op_a[0];
                ha_y = op_b[0];
            end
            PH_B: begin
                ha_x = p;
                ha_y = carry;
            end
            default: ;
        endcase
    end

    assign carry_out = g1 | ha_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            p         <= 1'b0;
            g1        <= 1'b0;
            idx       <= '0;
`ifdef SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PH_A;
                    end
                end
                PH_A: begin
                    p     <= ha_s;
                    g1    <= ha_c;
                    state <= PH_B;
                end
                PH_B: begin
                    sum[idx] <= ha_s;
                    carry    <= carry_out;
                    op_a     <= op_a >> 1;
                    op_b     <= op_b >> 1;
                    if (idx == LAST_IDX) begin
                        cout      <= carry_out;
`ifdef SIGNED_OVF_EN
                        // carry still holds the carry into the MSB at this edge
                        ovf       <= carry ^ carry_out;
`endif
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= PH_A;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
